// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-ported register file with a per-entry busy scoreboard.
//   Two write ports (port 1 wins on an address collision) and NUM_RD
//   combinational read ports. Entry 0 is hardwired to zero and is never busy.
//   The busy bit of an entry is set by an issue and cleared by a write to it;
//   an issue in the same cycle as a write to that entry wins.
// Optional feature: define RF_BYPASS_EN to forward same-cycle write data to
//   the read ports. Without it, a read returns the stored value.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   we0/wa0/wd0            write port 0 (enable, address, data)
//   we1/wa1/wd1            write port 1 (enable, address, data)
//   ra  [NUM_RD*ADDR_W]    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd  [NUM_RD*DATA_W]    packed read data (combinational), port k at [k*DATA_W +: DATA_W]
//   iss_en, iss_addr       issue strobe and destination register
//   rd_busy [NUM_RD]       busy bit of the register addressed by each read port
module reg_file_mp #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned NUM_RD = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we0,
  input  logic                       we1,
  input  logic [ADDR_W-1:0]          wa0,
  input  logic [ADDR_W-1:0]          wa1,
  input  logic [DATA_W-1:0]          wd0,
  input  logic [DATA_W-1:0]          wd1,
  input  logic [NUM_RD*ADDR_W-1:0]   ra,
  output logic [NUM_RD*DATA_W-1:0]   rd,
  input  logic                       iss_en,
  input  logic [ADDR_W-1:0]          iss_addr,
  output logic [NUM_RD-1:0]          rd_busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
    $error("reg_file_mp: NUM_RD must be in 1..4");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;

  // Storage; port 1 is applied last so it wins on a same-address write.
  always_ff @(posedge clk or posedge rst) begin : mem_update
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (we0 && (wa0 != '0)) mem[wa0] <= wd0;
      if (we1 && (wa1 != '0)) mem[wa1] <= wd1;
    end
  end

  // Scoreboard next state: writes clear, then an issue sets (new producer wins).
  always_comb begin : busy_next
    busy_nxt = busy;
    if (we0) busy_nxt[wa0] = 1'b0;
    if (we1) busy_nxt[wa1] = 1'b0;
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin : busy_reg
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // Read ports; outputs are forced to zero while reset is asserted.
  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] ra_k;
    logic [DATA_W-1:0] rd_k;

    assign ra_k = ra[k*ADDR_W +: ADDR_W];

    always_comb begin : read_mux
      rd_k = mem[ra_k];
`ifdef RF_BYPASS_EN
      if (we0 && (wa0 == ra_k)) rd_k = wd0;
      if (we1 && (wa1 == ra_k)) rd_k = wd1;
`endif
      if (rst || (ra_k == '0)) rd_k = '0;
    end

    assign rd[k*DATA_W +: DATA_W] = rd_k;
    assign rd_busy[k]             = ~rst & busy[ra_k];
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic        iss_en;
  logic [4:0]  iss_addr;
  logic [1:0]  rd_busy;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk(clk), .rst(rst),
    .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1),
    .ra(ra), .rd(rd), .iss_en(iss_en), .iss_addr(iss_addr), .rd_busy(rd_busy)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); ra = {5'd3, 5'd1};
    step(); step();
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL reset_rd got %h exp 0", rd);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++; $display("FAIL reset_busy got %b exp 00", rd_busy);
    end
    rst = 1'b0;
  endtask

  // First write right after reset release, then read on both ports.
  task automatic test_basic_write();
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hDEADBEEF;
    step();
    idle(); ra = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd[31:0] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL basic_write rd0 got %h exp deadbeef", rd[31:0]);
    end
    checks++;
    if (rd[63:32] !== 32'hDEADBEEF) begin
      errors++; $display("FAIL same_entry rd1 got %h exp deadbeef", rd[63:32]);
    end
  endtask

  task automatic test_write_priority();
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    step();
    idle(); ra = {5'd3, 5'd7};
    #1;
    checks++;
    if (rd[31:0] !== 32'h22) begin
      errors++; $display("FAIL write_priority got %h exp 00000022", rd[31:0]);
    end
  endtask

  task automatic test_zero_entry();
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF;
    we1 = 1'b1; wa1 = 5'd0; wd1 = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_addr = 5'd0;
    step();
    idle(); ra = {5'd0, 5'd0};
    #1;
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL zero_read got %h exp 0", rd);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++; $display("FAIL zero_busy got %b exp 00", rd_busy);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 5'd5;
    step();
    idle(); ra = {5'd6, 5'd5};
    #1;
    checks++;
    if (rd_busy !== 2'b01) begin
      errors++; $display("FAIL issue_sets got %b exp 01", rd_busy);
    end
    // Write and re-issue to the same entry: issue wins.
    we1 = 1'b1; wa1 = 5'd5; wd1 = 32'h55;
    iss_en = 1'b1; iss_addr = 5'd5;
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL busy_not_masked got %b exp 1", rd_busy[0]);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd_busy[0] !== 1'b1) begin
      errors++; $display("FAIL issue_wins got %b exp 1", rd_busy[0]);
    end
    checks++;
    if (rd[31:0] !== 32'h55) begin
      errors++; $display("FAIL issue_wins_data got %h exp 00000055", rd[31:0]);
    end
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'h66;
    step();
    idle();
    #1;
    checks++;
    if (rd_busy !== 2'b00) begin
      errors++; $display("FAIL write_clears got %b exp 00", rd_busy);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'hAAAA;
    step();
    idle(); ra = {5'd9, 5'd0};
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h1234;
    #1;
`ifdef RF_BYPASS_EN
    exp = 32'h1234;
`else
    exp = 32'hAAAA;
`endif
    checks++;
    if (rd[63:32] !== exp) begin
      errors++; $display("FAIL bypass_same_cycle got %h exp %h", rd[63:32], exp);
    end
    step();
    idle();
    #1;
    checks++;
    if (rd[63:32] !== 32'h1234) begin
      errors++; $display("FAIL bypass_next_cycle got %h exp 00001234", rd[63:32]);
    end
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h22;
    #1;
`ifdef RF_BYPASS_EN
    exp = 32'h22;
`else
    exp = 32'h1234;
`endif
    checks++;
    if (rd[63:32] !== exp) begin
      errors++; $display("FAIL bypass_dual got %h exp %h", rd[63:32], exp);
    end
    step();
    idle();
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      we0 = 1'b1; wa0 = 5'(i); wd0 = 32'h100 + 32'(i);
      iss_en = 1'b1; iss_addr = 5'(i);
      step();
    end
    idle(); ra = {5'd4, 5'd1};
    #1;
    checks++;
    if (rd !== {32'h104, 32'h101} || rd_busy !== 2'b11) begin
      errors++; $display("FAIL pre_reset got %h/%b exp 00000104_00000101/11", rd, rd_busy);
    end
    // Assert reset mid-cycle with a write and issue held.
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hBAD;
    iss_en = 1'b1; iss_addr = 5'd2;
    rst = 1'b1;
    #1;
    checks++;
    if (rd !== 64'h0 || rd_busy !== 2'b00) begin
      errors++; $display("FAIL async_reset got %h/%b exp 0/00", rd, rd_busy);
    end
    step();
    #1;
    rst = 1'b0;
    idle();
    for (int i = 1; i <= 4; i += 2) begin
      ra = {5'(i + 1), 5'(i)};
      #1;
      checks++;
      if (rd !== 64'h0 || rd_busy !== 2'b00) begin
        errors++; $display("FAIL post_reset_%0d got %h/%b exp 0/00", i, rd, rd_busy);
      end
    end
    // First write after release is accepted at the next edge.
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hC0DE;
    step();
    idle(); ra = {5'd2, 5'd2};
    #1;
    checks++;
    if (rd !== {32'hC0DE, 32'hC0DE}) begin
      errors++; $display("FAIL first_write_after_reset got %h exp 0000c0de_0000c0de", rd);
    end
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_write_priority();
    test_zero_entry();
    test_scoreboard();
    test_bypass();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 The block SHALL have parameter NUM_RD, default 2, number of read ports; legal range 1..4.
REQ-004 The block SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports we0, we1  input  1 each  write enables for write ports 0 and 1.
REQ-007 The block SHALL have ports wa0, wa1  input  ADDR_W each  write addresses.
REQ-008 The block SHALL have ports wd0, wd1  input  DATA_W each  write data.
REQ-009 The block SHALL have port ra  input  NUM_RD*ADDR_W  read addresses; port k uses slice [k*ADDR_W +: ADDR_W].
REQ-010 The block SHALL have port rd  output  NUM_RD*DATA_W  read data, combinational; port k uses slice [k*DATA_W +: DATA_W].
REQ-011 The block SHALL have port iss_en  input  1  issue strobe; marks register iss_addr as having a pending write.
REQ-012 The block SHALL have port iss_addr  input  ADDR_W  destination register of the issuing instruction.
REQ-013 The block SHALL have port rd_busy  output  NUM_RD  per read port; 1 = addressed register has a pending write.

Function
REQ-014 Entry 0 SHALL always read 0; writes and issues to address 0 SHALL be ignored.
REQ-015 A write with weN=1 SHALL update entry waN at the rising clk edge.
REQ-016 If we0=we1=1 and wa0==wa1, wd1 SHALL be written; port 1 has priority.
REQ-017 Reads SHALL be combinational with zero latency: rd[k] = entry ra[k], subject to REQ-025 and REQ-026.
REQ-018 Scoreboard: one busy bit per entry, entry 0 busy bit hardwired to 0.
REQ-019 iss_en=1 SHALL set busy[iss_addr] at the rising edge.
REQ-020 A write on either port SHALL clear busy[waN] at the rising edge.
REQ-021 If an issue and a write target the same address in the same cycle, busy SHALL end set, because the issue (new producer) wins.
REQ-022 rd_busy[k] SHALL equal busy[ra[k]] combinationally; it SHALL NOT be masked by a same-cycle write.
REQ-023 Multiple read ports addressing the same entry SHALL return identical data.
REQ-024 An address outside the entry range cannot occur; the depth is always the full 2**ADDR_W.

Reset
REQ-025 While rst=1, all entries SHALL read 0, all busy bits SHALL be 0, rd SHALL be 0 and rd_busy SHALL be 0, independent of clk.
REQ-026 Writes and issues presented while rst=1 SHALL be discarded.
REQ-027 rst asserted mid-operation SHALL clear state immediately, without waiting for a clock edge.
REQ-028 The first write SHALL be accepted at the first rising edge after rst deasserts.

Configuration
REQ-029 Macro RF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-030 With RF_BYPASS_EN defined, a read of address A in the same cycle as a write to A (A!=0, rst=0) SHALL return the incoming write data; when both ports write A, the returned data SHALL be wd1.
REQ-031 Without RF_BYPASS_EN, a read SHALL return the stored value in the write cycle and the new value from the next cycle.
REQ-032 The scoreboard SHALL behave identically with and without the macro.

Verification
REQ-033 Reset, then we0=1, wa0=3, wd0=0xDEADBEEF; with ra[0]=3 the next cycle -> rd[0]=0xDEADBEEF.
REQ-034 we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> entry 7 reads 0x22 the next cycle.
REQ-035 we0=1, wa0=0, wd0=0xFFFFFFFF -> ra[0]=0 reads 0; rd_busy[0]=0 after iss_en with iss_addr=0.
REQ-036 iss_en=1, iss_addr=5 -> rd_busy=1 for ra=5 the next cycle; we1=1, wa1=5 with iss_en=1, iss_addr=5 in the same cycle -> busy stays 1; a write alone then clears it.
REQ-037 Same-cycle write of 0x1234 to entry 9 with ra[1]=9 -> rd[1]=0x1234 in that cycle with RF_BYPASS_EN, and the old value without it.
REQ-038 Entries 1..4 written nonzero and busy set, then rst pulsed between edges -> all rd=0 and rd_busy=0 immediately; writes held during rst are not stored.
